// File: rtl/cache_evict_stress_gen.sv
// Cache eviction stress generator.
// Writes WAYS+EXTRA lines into each of SET_COUNT consecutive sets so that
// every set overflows its associativity and forces evictions. With VERIFY
// set, it then reads every line back and compares the data. A monitor on the
// DRAM port counts writebacks. Pass/fail is decided when the run ends.
//
// Ports:
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   start_i           one-cycle run request (ignored while busy_o)
//   cpu_addr_o        request address (0 outside a transaction)
//   cpu_wdata_o       write / expected read data (0 outside a transaction)
//   cpu_byte_en_o     4'b1111 during a transaction
//   cpu_rd_o/cpu_wr_o one-cycle request strobes
//   cpu_rdata_i       read data from the cache
//   cpu_ready_i       transaction complete, sampled only while waiting
//   mem_wr_i/mem_ready_i  DRAM write handshake being monitored
//   busy_o, done_o, pass_o, timeout_o   run status
//   wb_count_o, err_count_o             saturating counters
//
// state | meaning
// IDLE  | waiting for start after reset
// REQ   | strobe cpu_wr/cpu_rd for one cycle
// WAIT  | wait for cpu_ready, down-counting the timeout
// GAP   | idle spacing between transactions
// DONE  | results held until the next start
module cache_evict_stress_gen #(
  parameter int unsigned WAYS       = 8,
  parameter int unsigned EXTRA      = 1,
  parameter int unsigned INDEX_LSB  = 6,
  parameter int unsigned INDEX_BITS = 8,
  parameter int unsigned SET_FIRST  = 16,
  parameter int unsigned SET_COUNT  = 4,
  parameter logic [31:0] DATA_BASE  = 32'hCAFE_0000,
  parameter int unsigned GAP        = 2,
  parameter int unsigned VERIFY     = 1,
  parameter int unsigned TIMEOUT    = 1024,
  parameter int unsigned MIN_WB     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  output logic [31:0] cpu_addr_o,
  output logic [31:0] cpu_wdata_o,
  output logic [3:0]  cpu_byte_en_o,
  output logic        cpu_rd_o,
  output logic        cpu_wr_o,
  input  logic [31:0] cpu_rdata_i,
  input  logic        cpu_ready_i,
  input  logic        mem_wr_i,
  input  logic        mem_ready_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic        timeout_o,
  output logic [15:0] wb_count_o,
  output logic [15:0] err_count_o
);

  localparam int unsigned L  = WAYS + EXTRA;
  localparam int unsigned NW = (L > 1) ? $clog2(L) : 1;
  localparam logic [NW-1:0]         N_LAST  = NW'(L - 1);
  localparam logic [INDEX_BITS-1:0] S_FIRST = INDEX_BITS'(SET_FIRST);
  localparam logic [INDEX_BITS-1:0] S_LAST  = INDEX_BITS'(SET_FIRST + SET_COUNT - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_GAP, ST_DONE} state_e;

  state_e                state_q, state_d;
  logic                  phase_q, phase_d;   // 0: write pass, 1: read-back pass
  logic [NW-1:0]         n_q, n_d;
  logic [INDEX_BITS-1:0] s_q, s_d;
  logic [31:0]           timer_q, timer_d;   // shared by WAIT and GAP
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic                  timeout_q, timeout_d;
  logic [15:0]           wb_q, wb_d;
  logic [15:0]           err_q, err_d;
  logic                  advance, finish, in_txn;
  logic [31:0]           addr_w, data_w;

  // Line number lands in the tag field; bits beyond the tag width fall off.
  assign addr_w = (32'(n_q) << (INDEX_BITS + INDEX_LSB)) | (32'(s_q) << INDEX_LSB);
  assign data_w = DATA_BASE + (32'(s_q) << 8) + 32'(n_q);
  assign in_txn = (state_q == ST_REQ) || (state_q == ST_WAIT);

  assign cpu_addr_o    = in_txn ? addr_w : 32'd0;
  assign cpu_wdata_o   = in_txn ? data_w : 32'd0;
  assign cpu_byte_en_o = in_txn ? 4'b1111 : 4'b0000;
  assign cpu_wr_o      = (state_q == ST_REQ) && !phase_q;
  assign cpu_rd_o      = (state_q == ST_REQ) && phase_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign pass_o        = pass_q;
  assign timeout_o     = timeout_q;
  assign wb_count_o    = wb_q;
  assign err_count_o   = err_q;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    n_d       = n_q;
    s_d       = s_q;
    timer_d   = timer_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    timeout_d = timeout_q;
    wb_d      = wb_q;
    err_d     = err_q;
    advance   = 1'b0;
    finish    = 1'b0;

    if (busy_q && mem_wr_i && mem_ready_i && (wb_q != 16'hFFFF)) wb_d = wb_q + 16'd1;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          wb_d      = 16'd0;
          err_d     = 16'd0;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          busy_d    = 1'b1;
          n_d       = '0;
          s_d       = S_FIRST;
          phase_d   = 1'b0;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        timer_d = TIMEOUT - 1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cpu_ready_i) begin
          if (phase_q && (cpu_rdata_i != data_w) && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
          advance = 1'b1;
        end else if (timer_q == 32'd0) begin
          timeout_d = 1'b1;
          finish    = 1'b1;
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end
      ST_GAP: begin
        if (timer_q == 32'd0) state_d = ST_REQ;
        else                  timer_d = timer_q - 32'd1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Line pointer moves on at WAIT exit; addr/data are gated off in GAP.
    if (advance) begin
      if (n_q != N_LAST) begin
        n_d = n_q + NW'(1);
      end else begin
        n_d = '0;
        if (s_q != S_LAST) begin
          s_d = s_q + INDEX_BITS'(1);
        end else begin
          s_d = S_FIRST;
          if (!phase_q && (VERIFY != 0)) phase_d = 1'b1;
          else                           finish  = 1'b1;
        end
      end
      if (!finish) begin
        if (GAP == 0) begin
          state_d = ST_REQ;
        end else begin
          timer_d = GAP - 1;
          state_d = ST_GAP;
        end
      end
    end

    // Verdict uses next-state counters so a same-cycle increment is included.
    if (finish) begin
      state_d = ST_DONE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      pass_d  = (err_d == 16'd0) && (32'(wb_d) >= MIN_WB) && !timeout_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      phase_q   <= 1'b0;
      n_q       <= '0;
      s_q       <= '0;
      timer_q   <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      wb_q      <= 16'd0;
      err_q     <= 16'd0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      n_q       <= n_d;
      s_q       <= s_d;
      timer_q   <= timer_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
      wb_q      <= wb_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_cache_evict_stress_gen.sv
module tb_cache_evict_stress_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]  cpu_byte_en;
  logic        cpu_rd, cpu_wr, cpu_ready, mem_wr, mem_ready;
  logic        busy, done, pass, timeout;
  logic [15:0] wb_count, err_count;

  always #5 clk = ~clk;

  cache_evict_stress_gen dut (
    .clk(clk), .rst_n(rst_n), .start_i(start),
    .cpu_addr_o(cpu_addr), .cpu_wdata_o(cpu_wdata), .cpu_byte_en_o(cpu_byte_en),
    .cpu_rd_o(cpu_rd), .cpu_wr_o(cpu_wr), .cpu_rdata_i(cpu_rdata), .cpu_ready_i(cpu_ready),
    .mem_wr_i(mem_wr), .mem_ready_i(mem_ready),
    .busy_o(busy), .done_o(done), .pass_o(pass), .timeout_o(timeout),
    .wb_count_o(wb_count), .err_count_o(err_count)
  );

  localparam int LINES = 9;
  localparam int SETS  = 4;
  localparam int FIRST = 16;

  int checks = 0;
  int errors = 0;

  // memory model / monitor state
  bit          corrupt, stuck, no_wb, ready_high;
  int          exp_spacing;
  int          cyc = 0;
  int          txn, wr_pulses, seq_bad, hold_bad, gap_bad;
  int          first_cyc, last_cyc, to_cyc, pend_cnt;
  bit          pend_rd;
  logic [31:0] hold_addr, hold_data;
  logic [31:0] mem [logic [31:0]];

  typedef struct {
    bit corrupt, stuck, no_wb, ready_high, pulse_start;
    int exp_txn, exp_wr, exp_wb, exp_err;
    bit exp_pass, exp_timeout;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void exp_txn(input int k, output logic [31:0] a, output logic [31:0] d,
                                  output bit rd);
    int per, idx, s, n;
    per = SETS * LINES;
    idx = k % per;
    s   = FIRST + idx / LINES;
    n   = idx % LINES;
    rd  = (k >= per);
    a   = (32'(n) << 14) | (32'(s) << 6);
    d   = 32'hCAFE_0000 + (32'(s) << 8) + 32'(n);
  endfunction

  // Responder: ready 3 cycles after each strobe, writeback pulse on the
  // completion of each line-8 write, read data from a write-back memory.
  initial begin
    logic [31:0] ea, ed, a;
    bit          erd;
    int          d;
    cpu_ready = 1'b0; mem_wr = 1'b0; mem_ready = 1'b0; cpu_rdata = 32'd0;
    forever begin
      @(negedge clk);
      cyc++;
      cpu_ready = ready_high;
      mem_wr    = 1'b0;
      mem_ready = 1'b0;
      if (timeout && to_cyc < 0) to_cyc = cyc;
      if (pend_cnt > 0) begin
        if (!ready_high && (cpu_addr !== hold_addr || cpu_wdata !== hold_data ||
                            cpu_byte_en !== 4'hF)) hold_bad++;
        pend_cnt--;
        if (pend_cnt == 0) begin
          if (!stuck) cpu_ready = 1'b1;
          if (!pend_rd && !no_wb && hold_addr[31:14] == 18'd8) begin
            mem_wr = 1'b1; mem_ready = 1'b1;
          end
        end
      end
      if (cpu_wr || cpu_rd) begin
        exp_txn(txn, ea, ed, erd);
        if ((cpu_wr && cpu_rd) || cpu_addr !== ea || cpu_wdata !== ed || cpu_rd !== erd ||
            cpu_byte_en !== 4'hF) seq_bad++;
        if (cpu_wr) begin
          mem[cpu_addr] = cpu_wdata;
          wr_pulses++;
        end
        if (txn > 0) begin
          d = cyc - last_cyc;
          if (d != exp_spacing) gap_bad++;
        end else begin
          first_cyc = cyc;
        end
        last_cyc  = cyc;
        txn++;
        hold_addr = cpu_addr;
        hold_data = cpu_wdata;
        pend_rd   = cpu_rd;
        pend_cnt  = 3;
      end
      a = cpu_addr;
      if (corrupt && a == 32'h0000_0400) cpu_rdata = 32'd0;
      else if (mem.exists(a))            cpu_rdata = mem[a];
      else                               cpu_rdata = 32'hDEAD_BEEF;
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_mode(input vec_t v);
    corrupt     = v.corrupt;
    stuck       = v.stuck;
    no_wb       = v.no_wb;
    ready_high  = v.ready_high;
    exp_spacing = v.ready_high ? 4 : 6;
  endtask

  task automatic start_run();
    txn = 0; wr_pulses = 0; seq_bad = 0; hold_bad = 0; gap_bad = 0;
    first_cyc = -1; last_cyc = 0; to_cyc = -1; pend_cnt = 0;
    mem.delete();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s done not seen within %0d cycles", name, budget);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int lat, t0;
    vec_t nv;
    //        cor stk nwb rh  ps  txn wr  wb err pass to
    vecs[0] = '{0, 0, 0, 0, 0, 72, 36, 4, 0, 1, 0};
    vecs[1] = '{1, 0, 0, 0, 0, 72, 36, 4, 1, 0, 0};
    vecs[2] = '{0, 0, 1, 0, 0, 72, 36, 0, 0, 0, 0};
    vecs[3] = '{0, 0, 0, 1, 1, 72, 36, 4, 0, 1, 0};
    vecs[4] = '{0, 1, 1, 0, 0,  1,  1, 0, 0, 0, 1};

    rst_n = 1'b0; start = 1'b0;
    set_mode(vecs[0]);
    txn = 0; pend_cnt = 0; to_cyc = -1;
    #3;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_pass", 32'(pass), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_counts", {wb_count, err_count}, 0);
    check("rst_addr", cpu_addr, 0);
    check("rst_wdata", cpu_wdata, 0);
    check("rst_strobes", {26'd0, cpu_byte_en, cpu_rd, cpu_wr}, 0);
    tick(1);
    rst_n = 1'b1;
    tick(3);
    check("idle_no_start", 32'(busy), 0);

    for (int i = 0; i < 5; i++) begin
      set_mode(vecs[i]);
      start_run();
      check($sformatf("v%0d_busy_start", i), 32'(busy), 1);
      if (vecs[i].pulse_start) begin
        tick(40);
        start = 1'b1;
        tick(1);
        start = 1'b0;
      end
      wait_done($sformatf("v%0d_done", i), 5000);
      tick(2);
      check($sformatf("v%0d_txn", i), txn, vecs[i].exp_txn);
      check($sformatf("v%0d_wr_pulses", i), wr_pulses, vecs[i].exp_wr);
      check($sformatf("v%0d_wb", i), 32'(wb_count), vecs[i].exp_wb);
      check($sformatf("v%0d_err", i), 32'(err_count), vecs[i].exp_err);
      check($sformatf("v%0d_pass", i), 32'(pass), 32'(vecs[i].exp_pass));
      check($sformatf("v%0d_timeout", i), 32'(timeout), 32'(vecs[i].exp_timeout));
      check($sformatf("v%0d_done_busy", i), {30'd0, done, busy}, 32'b10);
      check($sformatf("v%0d_sequence", i), seq_bad, 0);
      check($sformatf("v%0d_hold", i), hold_bad, 0);
      check($sformatf("v%0d_spacing", i), gap_bad, 0);
      if (vecs[i].exp_timeout) begin
        // WAIT spans TIMEOUT cycles after the REQ cycle
        lat = to_cyc - first_cyc;
        checks++;
        if (!(lat == 1024 || lat == 1025)) begin
          errors++;
          $display("FAIL timeout_latency actual=%0d required=1024..1025", lat);
        end
      end
    end

    // reset asserted mid-run during WAIT of line 5 set 17
    set_mode(vecs[0]);
    start_run();
    t0 = 0;
    while (txn < 15 && t0 < 500) begin
      tick(1);
      t0++;
    end
    check("mid_line", hold_addr, (32'd5 << 14) | (32'd17 << 6));
    check("mid_wb_before", 32'(wb_count), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_status", {28'd0, busy, done, pass, timeout}, 0);
    check("mid_rst_counts", {wb_count, err_count}, 0);
    check("mid_rst_addr", cpu_addr, 0);
    check("mid_rst_wdata", cpu_wdata, 0);
    check("mid_rst_strobes", {26'd0, cpu_byte_en, cpu_rd, cpu_wr}, 0);
    tick(2);
    rst_n = 1'b1;
    t0 = txn;
    tick(20);
    check("no_resume_busy", 32'(busy), 0);
    check("no_resume_txn", txn, t0);
    nv = vecs[0];
    set_mode(nv);
    start_run();
    wait_done("rerun_done", 5000);
    tick(10);
    check("rerun_txn", txn, 72);
    check("rerun_pass", 32'(pass), 1);
    check("rerun_hold_done", 32'(done), 1);
    check("rerun_hold_wb", 32'(wb_count), 4);
    check("rerun_sequence", seq_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_evict_stress_gen.md
CACHE_EVICT_STRESS_GEN -- requirements
Module: cache_evict_stress_gen

Interface
REQ-001 SHALL have parameter WAYS, 8, target cache associativity.
REQ-002 SHALL have parameter EXTRA, 1, lines per set beyond WAYS; each set gets L = WAYS+EXTRA lines.
REQ-003 SHALL have parameter INDEX_LSB, 6, lowest address bit of the set index.
REQ-004 SHALL have parameter INDEX_BITS, 8, set index width.
REQ-005 SHALL have parameter SET_FIRST, 16, first set exercised.
REQ-006 SHALL have parameter SET_COUNT, 4, number of consecutive sets exercised; SET_FIRST+SET_COUNT <= 2^INDEX_BITS.
REQ-007 SHALL have parameter DATA_BASE, 32'hCAFE_0000, write-data base.
REQ-008 SHALL have parameter GAP, 2, idle cycles between transactions.
REQ-009 SHALL have parameter VERIFY, 1, enable the read-back phase.
REQ-010 SHALL have parameter TIMEOUT, 1024, maximum cycles to wait for cpu_ready.
REQ-011 SHALL have parameter MIN_WB, 1, minimum DRAM writebacks required for pass.
REQ-012 clk  in  1  single clock, rising edge.
REQ-013 rst_n  in  1  asynchronous active-low reset.
REQ-014 start  in  1  one-cycle run request.
REQ-015 cpu_addr  out  32  request address.
REQ-016 cpu_wdata  out  32  write data.
REQ-017 cpu_byte_en  out  4  byte enables, 4'b1111 during requests.
REQ-018 cpu_rd / cpu_wr  out  1 each  request strobes.
REQ-019 cpu_rdata  in  32  read data.
REQ-020 cpu_ready  in  1  transaction complete.
REQ-021 mem_wr / mem_ready  in  1 each  DRAM-port monitor inputs.
REQ-022 busy, done, pass, timeout  out  1 each  status.
REQ-023 wb_count, err_count  out  16 each  counters.

Function
REQ-024 Line n (0..L-1) of set s SHALL use address {n[tag bits], s[INDEX_BITS-1:0], INDEX_LSB'b0}, data DATA_BASE + (s<<8) + n, 32-bit wrap.
REQ-025 States SHALL be IDLE, REQ, WAIT, GAP, DONE; phase bit WR then RD.
REQ-026 IDLE/DONE + start SHALL clear counters, done, pass, timeout; set busy; go REQ at n=0, s=SET_FIRST, phase WR.
REQ-027 start SHALL be ignored while busy.
REQ-028 REQ SHALL drive address/data and assert cpu_wr (WR) or cpu_rd (RD) for exactly one cycle, then enter WAIT.
REQ-029 cpu_addr/cpu_wdata SHALL hold stable from REQ until WAIT exits.
REQ-030 cpu_ready SHALL be sampled only in WAIT; ready in the REQ cycle is ignored.
REQ-031 In RD phase, on cpu_ready, cpu_rdata != expected data SHALL increment err_count (saturating at 16'hFFFF).
REQ-032 WAIT SHALL count cycles; reaching TIMEOUT without cpu_ready SHALL set timeout and go DONE.
REQ-033 After ready, GAP cycles SHALL elapse (GAP=0: next REQ immediately); n increments, wraps to 0 at L with s incremented.
REQ-034 After the last line of the last set: WR with VERIFY=1 SHALL restart at line 0 of SET_FIRST in RD; otherwise go DONE.
REQ-035 wb_count SHALL increment on every cycle with mem_wr && mem_ready while busy, saturating at 16'hFFFF.
REQ-036 Entering DONE SHALL clear busy, set done, and set pass = (err_count==0) && (wb_count>=MIN_WB) && !timeout, evaluated including any same-cycle increments.
REQ-037 done, pass, counters SHALL hold until the next accepted start.
REQ-038 Total transactions SHALL be SET_COUNT*L*(1+VERIFY).

Reset
REQ-039 rst_n low SHALL immediately force IDLE, all outputs 0, counters 0, regardless of state.
REQ-040 Reset release mid-run SHALL NOT resume; a new start is required.

Verification
REQ-041 Defaults, ideal memory with ready 3 cycles after request, writebacks on 9th line per set -> 72 transactions, wb_count=4, err_count=0, pass=1.
REQ-042 Memory corrupts read of line 0 set 16 (returns 0) -> err_count=1, pass=0.
REQ-043 cpu_ready stuck 0 -> timeout=1 at 1024 cycles after first REQ, done=1, pass=0, cpu_wr pulse count 1.
REQ-044 No mem_wr activity, MIN_WB=1 -> wb_count=0, pass=0.
REQ-045 rst_n low during WAIT of line 5 set 17 -> outputs 0 asynchronously; start re-run completes with pass=1.
REQ-046 start pulsed while busy, and cpu_ready held high continuously -> start ignored; one transaction per REQ, GAP=2 observed.
